// File: rtl/bfp16_pkg.sv
// Shared BFP16 PE-port definitions: operand width, zero operand, ctrl encodings
// and the weight-stationary feeder state type.
package bfp16_pkg;

    localparam int unsigned DATA_TYPE_DEFAULT = 16;
    localparam logic [15:0] BFP16_ZERO        = 16'h0000;

    localparam logic CTRL_LOAD_W = 1'b0;
    localparam logic CTRL_PSUM   = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_STREAM = 2'd2,
        ST_DONE   = 2'd3
    } feeder_state_t;

endpackage

// File: rtl/bfp16_ws_feeder_if.sv
// Weight stream, ifmap/psum stream and PE drive port of the weight-stationary feeder.
interface bfp16_ws_feeder_if
    import bfp16_pkg::*;
#(
    parameter int unsigned DATA_TYPE = DATA_TYPE_DEFAULT
) ();

    logic                 w_valid;
    logic                 w_ready;
    logic [DATA_TYPE-1:0] w_data;

    logic                 x_valid;
    logic                 x_ready;
    logic [DATA_TYPE-1:0] x_ifmap;
    logic [DATA_TYPE-1:0] x_psum;

    logic                 pe_ctrl;
    logic [DATA_TYPE-1:0] pe_in;
    logic [DATA_TYPE-1:0] pe_ifmap;
    logic                 pe_vld;

    // Environment side: sources the operand streams, observes the PE drive.
    modport master (
        output w_valid, w_data, x_valid, x_ifmap, x_psum,
        input  w_ready, x_ready, pe_ctrl, pe_in, pe_ifmap, pe_vld
    );

    // Feeder side: sinks the operand streams, drives the PE.
    modport slave (
        input  w_valid, w_data, x_valid, x_ifmap, x_psum,
        output w_ready, x_ready, pe_ctrl, pe_in, pe_ifmap, pe_vld
    );

endinterface

// File: rtl/bfp16_ws_feeder.sv
// Sequences a weight load phase then an ifmap/psum compute phase into the head
// of a BFP16 weight-stationary PE chain, inserting safe bubbles on stalls.
module bfp16_ws_feeder
    import bfp16_pkg::*;
#(
    parameter int unsigned DATA_TYPE = DATA_TYPE_DEFAULT,
    parameter int unsigned NUM_W     = 4,
    parameter int unsigned MAX_LEN   = 256,
    localparam int unsigned LEN_W    = $clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             flush,
    bfp16_ws_feeder_if.slave bus,
    output logic             busy,
    output logic             done
);

    localparam logic [DATA_TYPE-1:0] ZERO_OP = DATA_TYPE'(BFP16_ZERO);
    localparam logic [LEN_W-1:0]     LEN_MAX = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0]     W_LAST  = LEN_W'(NUM_W - 1);

    feeder_state_t        state, state_d;
    logic [LEN_W-1:0]     cnt, cnt_d;
    logic [LEN_W-1:0]     len_q, len_d;
    logic                 pe_ctrl_d, pe_vld_d;
    logic [DATA_TYPE-1:0] pe_in_d, pe_ifmap_d;
    logic                 w_hs, x_hs;

    // Readies depend on state only, so they never combinationally follow valid.
    assign bus.w_ready = (state == ST_LOAD);
    assign bus.x_ready = (state == ST_STREAM);
    assign w_hs        = bus.w_valid & bus.w_ready;
    assign x_hs        = bus.x_valid & bus.x_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            len_q <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            len_q <= len_d;
        end
    end

    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        len_d      = len_q;
        pe_ctrl_d  = CTRL_PSUM;
        pe_in_d    = ZERO_OP;
        pe_ifmap_d = ZERO_OP;
        pe_vld_d   = 1'b0;

        if (flush) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        len_d   = (len > LEN_MAX) ? LEN_MAX : len;
                        cnt_d   = '0;
                        state_d = ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (w_hs) begin
                        pe_ctrl_d = CTRL_LOAD_W;
                        pe_in_d   = bus.w_data;
                        pe_vld_d  = 1'b1;
                        if (cnt == W_LAST) begin
                            cnt_d   = '0;
                            state_d = (len_q == '0) ? ST_DONE : ST_STREAM;
                        end else begin
                            cnt_d = cnt + LEN_W'(1);
                        end
                    end
                end
                ST_STREAM: begin
                    if (x_hs) begin
                        pe_ctrl_d  = CTRL_PSUM;
                        pe_in_d    = bus.x_psum;
                        pe_ifmap_d = bus.x_ifmap;
                        pe_vld_d   = 1'b1;
                        if (cnt == len_q - LEN_W'(1)) begin
                            cnt_d   = '0;
                            state_d = ST_DONE;
                        end else begin
                            cnt_d = cnt + LEN_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Registered PE drive and status; done/busy track the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.pe_ctrl  <= CTRL_PSUM;
            bus.pe_in    <= ZERO_OP;
            bus.pe_ifmap <= ZERO_OP;
            bus.pe_vld   <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            bus.pe_ctrl  <= pe_ctrl_d;
            bus.pe_in    <= pe_in_d;
            bus.pe_ifmap <= pe_ifmap_d;
            bus.pe_vld   <= pe_vld_d;
            busy         <= (state_d != ST_IDLE);
            done         <= (state_d == ST_DONE);
        end
    end

endmodule

// File: tb/tb_bfp16_ws_feeder.sv
// Randomized scoreboard bench for bfp16_ws_feeder: expected PE drives are queued
// from the command stimulus and checked by an independent output monitor.
module tb_bfp16_ws_feeder;

    localparam int unsigned DW      = 16;
    localparam int unsigned NUM_W   = 4;
    localparam int unsigned MAX_LEN = 256;
    localparam int unsigned LEN_W   = $clog2(MAX_LEN + 1);

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [LEN_W-1:0] len;
    logic             flush;
    logic             busy;
    logic             done;

    bfp16_ws_feeder_if #(.DATA_TYPE(DW)) bus ();

    bfp16_ws_feeder #(
        .DATA_TYPE (DW),
        .NUM_W     (NUM_W),
        .MAX_LEN   (MAX_LEN)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .len   (len),
        .flush (flush),
        .bus   (bus),
        .busy  (busy),
        .done  (done)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cyc = 0;
    int done_cnt = 0;
    int done_exp = 0;
    int w_pct = 100;
    int x_pct = 100;
    bit len0_mode = 0;

    logic [DW-1:0]     wq[$];      // weights offered on the w stream
    logic [2*DW-1:0]   xq[$];      // {ifmap, psum} offered on the x stream
    logic [2*DW:0]     exp_q[$];   // expected {ctrl, in, ifmap} per real PE drive

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Reference model: a weight drives (load, w, 0); a pair drives (psum-pass, psum, ifmap).
    task automatic add_w(input logic [DW-1:0] w);
        wq.push_back(w);
        exp_q.push_back({1'b0, w, 16'h0000});
    endtask

    task automatic add_x(input logic [DW-1:0] ifm, input logic [DW-1:0] ps);
        xq.push_back({ifm, ps});
        exp_q.push_back({1'b1, ps, ifm});
    endtask

    // Weight source
    initial begin
        bit hs;
        bus.w_valid = 1'b0;
        bus.w_data  = '0;
        forever begin
            @(negedge clk);
            hs = bus.w_valid && bus.w_ready;
            @(posedge clk);
            #1;
            if (hs && wq.size() > 0) void'(wq.pop_front());
            if (wq.size() > 0 && $urandom_range(99) < w_pct) begin
                bus.w_valid = 1'b1;
                bus.w_data  = wq[0];
            end else begin
                bus.w_valid = 1'b0;
                bus.w_data  = DW'($urandom);
            end
        end
    end

    // Ifmap/psum source
    initial begin
        bit hs;
        bus.x_valid = 1'b0;
        bus.x_ifmap = '0;
        bus.x_psum  = '0;
        forever begin
            @(negedge clk);
            hs = bus.x_valid && bus.x_ready;
            @(posedge clk);
            #1;
            if (hs && xq.size() > 0) void'(xq.pop_front());
            if (xq.size() > 0 && $urandom_range(99) < x_pct) begin
                bus.x_valid = 1'b1;
                bus.x_ifmap = xq[0][2*DW-1:DW];
                bus.x_psum  = xq[0][DW-1:0];
            end else begin
                bus.x_valid = 1'b0;
                bus.x_ifmap = DW'($urandom);
                bus.x_psum  = DW'($urandom);
            end
        end
    end

    // Output monitor
    initial begin
        logic [2*DW:0] e;
        forever begin
            @(negedge clk);
            chk("ready_exclusive", 64'(bus.w_ready & bus.x_ready), 64'd0);
            if (len0_mode) chk("len0_x_ready", 64'(bus.x_ready), 64'd0);
            if (bus.pe_vld) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_item", 64'(exp_q.size()), 64'd1);
                end else begin
                    e = exp_q.pop_front();
                    chk("pe_item", 64'({bus.pe_ctrl, bus.pe_in, bus.pe_ifmap}), 64'(e));
                end
            end else begin
                chk("bubble", 64'({bus.pe_ctrl, bus.pe_in, bus.pe_ifmap}), 64'({1'b1, 32'd0}));
            end
            if (done) done_cnt++;
        end
    end

    task automatic issue(input int unsigned l);
        @(posedge clk);
        #1;
        start = 1'b1;
        len   = LEN_W'(l);
        @(posedge clk);
        #1;
        start     = 1'b0;
        start_cyc = cyc;
        chk("busy_w_ready_rise", 64'({busy, bus.w_ready}), 64'd3);
    endtask

    task automatic wait_done(input int budget, input int exp_lat);
        bit found = 0;
        done_exp++;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (done) begin
                found = 1;
                break;
            end
        end
        chk("done_timeout", 64'(found), 64'd1);
        if (found) begin
            chk("done_last_drive", 64'(bus.pe_vld), 64'd1);
            chk("done_queue_empty", 64'(exp_q.size()), 64'd0);
            chk("busy_in_done", 64'(busy), 64'd1);
            if (exp_lat >= 0) chk("done_latency", 64'(cyc - start_cyc), 64'(exp_lat));
            @(posedge clk);
            #1;
            chk("busy_done_fall", 64'({busy, done}), 64'd0);
        end
    endtask

    task automatic rand_cmd(input int unsigned l);
        for (int i = 0; i < int'(NUM_W); i++) add_w(DW'($urandom));
        for (int i = 0; i < int'(l); i++) add_x(DW'($urandom), DW'($urandom));
        issue(l);
        wait_done(30 * (int'(NUM_W) + int'(l)) + 20, -1);
    endtask

    initial begin
        int unsigned l;
        rst_n = 1'b0;
        start = 1'b0;
        len   = '0;
        flush = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_values",
            64'({bus.pe_ctrl, bus.pe_in, bus.pe_ifmap, bus.pe_vld, busy, done, bus.w_ready, bus.x_ready}),
            64'({1'b1, 37'd0}));
        @(negedge clk);
        rst_n = 1'b1;

        // Basic no-stall command
        w_pct = 100; x_pct = 100;
        add_w(16'h4040); add_w(16'h4100); add_w(16'h4480); add_w(16'h3FA0);
        add_x(16'h3F80, 16'h4040); add_x(16'h449B, 16'h461B);
        add_x(16'h4600, 16'h4B00); add_x(16'h4020, 16'h4048);
        issue(4);
        wait_done(40, int'(NUM_W) + 4);

        // Random stalls on both streams
        w_pct = 50; x_pct = 50;
        repeat (6) rand_cmd($urandom_range(1, 12));

        // len=0: load phase only, pending pair must stay untouched
        len0_mode = 1;
        xq.push_back(32'h1234_5678);
        for (int i = 0; i < int'(NUM_W); i++) add_w(DW'($urandom));
        issue(0);
        wait_done(200, -1);
        @(negedge clk);
        len0_mode = 0;
        chk("len0_pair_left", 64'(xq.size()), 64'd1);
        xq.delete();

        // Flush mid-STREAM after 2 of 4 pairs
        w_pct = 100; x_pct = 100;
        for (int i = 0; i < int'(NUM_W); i++) add_w(DW'($urandom));
        add_x(DW'($urandom), DW'($urandom));
        add_x(DW'($urandom), DW'($urandom));
        issue(4);
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        #1;
        chk("pre_flush_stream", 64'({busy, bus.x_ready, exp_q.size() == 0}), 64'd7);
        @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_idle", 64'({busy, done, bus.pe_vld, bus.pe_ctrl, bus.x_ready, bus.w_ready}), 64'b000100);
        xq.push_back(32'hABCD_0123);
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("flush_no_consume", 64'(xq.size()), 64'd1);
        xq.delete();

        // Async reset mid-LOAD right after the second weight is driven
        add_w(16'h1111);
        wq.push_back(16'h2222);
        issue(3);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("pre_reset_drive", 64'({bus.pe_vld, bus.pe_ctrl, bus.pe_in}), 64'({2'b10, 16'h2222}));
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset",
            64'({bus.pe_ctrl, bus.pe_in, bus.pe_ifmap, bus.pe_vld, busy, done, bus.w_ready, bus.x_ready}),
            64'({1'b1, 37'd0}));
        chk("reset_queue", 64'(exp_q.size() + wq.size()), 64'd0);
        wq.delete();
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        w_pct = 50; x_pct = 50;
        rand_cmd(5);

        // start while busy is ignored
        w_pct = 100; x_pct = 100;
        for (int i = 0; i < int'(NUM_W); i++) add_w(DW'($urandom));
        for (int i = 0; i < 6; i++) add_x(DW'($urandom), DW'($urandom));
        issue(6);
        repeat (2) @(posedge clk);
        #1;
        start = 1'b1;
        len   = LEN_W'(2);
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(60, int'(NUM_W) + 6);

        // start together with flush is dropped
        @(posedge clk);
        #1;
        start = 1'b1;
        flush = 1'b1;
        len   = LEN_W'(3);
        @(posedge clk);
        #1;
        start = 1'b0;
        flush = 1'b0;
        chk("start_flush_drop", 64'({busy, bus.w_ready}), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("start_flush_still_idle", 64'({busy, done, bus.w_ready, bus.x_ready}), 64'd0);

        // len above MAX_LEN saturates
        for (int i = 0; i < int'(NUM_W); i++) add_w(DW'($urandom));
        for (int i = 0; i < int'(MAX_LEN); i++) add_x(DW'($urandom), DW'($urandom));
        for (int i = 0; i < 5; i++) xq.push_back($urandom);
        l = MAX_LEN + 5;
        issue(l);
        wait_done(600, int'(NUM_W) + int'(MAX_LEN));
        @(negedge clk);
        chk("saturate_leftover", 64'(xq.size()), 64'd5);
        xq.delete();

        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk("done_count", 64'(done_cnt), 64'(done_exp));
        chk("expected_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
